// File: rtl/intersection_pkg.sv
// intersection_pkg: shared state encoding, light patterns and requester indices
package intersection_pkg;
  typedef enum logic [2:0] {
    G_NS   = 3'd0,
    Y_NS   = 3'd1,
    R_NS   = 3'd2,
    G_EW   = 3'd3,
    Y_EW   = 3'd4,
    R_EW   = 3'd5,
    WALK   = 3'd6,
    R_WALK = 3'd7
  } state_e;
  localparam logic [5:0] L_G_NS    = 6'b100_001;
  localparam logic [5:0] L_Y_NS    = 6'b010_001;
  localparam logic [5:0] L_G_EW    = 6'b001_100;
  localparam logic [5:0] L_Y_EW    = 6'b001_010;
  localparam logic [5:0] L_ALL_RED = 6'b001_001;
  localparam int NS  = 0;
  localparam int EW  = 1;
  localparam int PED = 2;
endpackage

// File: rtl/intersection_scheduler_phase_timer.sv
// phase_timer: saturating phase counter with synchronous clear
module phase_timer #(
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr_i,
  output logic [CNT_W-1:0] cnt_o
);
  logic [CNT_W-1:0] cnt_q, cnt_d;
  // clear on phase change, otherwise count up and hold at all-ones
  always_comb cnt_d = clr_i ? '0 : (&cnt_q ? cnt_q : cnt_q + 1'b1);
  // counter register
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt_q <= '0;
    else cnt_q <= cnt_d;
  assign cnt_o = cnt_q;
endmodule

// File: rtl/intersection_scheduler.sv
// intersection_scheduler: round-robin timed phase sequencer for NS, EW and pedestrian
module intersection_scheduler
  import intersection_pkg::*;
#(
  parameter int CNT_W       = 4,
  parameter int T_MIN_GREEN = 4,
  parameter int T_MAX_GREEN = 10,
  parameter int T_YELLOW    = 2,
  parameter int T_ALL_RED   = 1,
  parameter int T_WALK      = 6
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       car_ns_i,
  input  logic       car_ew_i,
  input  logic       ped_req_i,
  output logic [5:0] lights_o,
  output logic       walk_o,
  output logic [2:0] phase_o
);
  localparam logic [CNT_W-1:0] MIN_END = CNT_W'(T_MIN_GREEN - 1);
  localparam logic [CNT_W-1:0] MAX_END = CNT_W'(T_MAX_GREEN - 1);
  localparam logic [CNT_W-1:0] YEL_END = CNT_W'(T_YELLOW - 1);
  localparam logic [CNT_W-1:0] AR_END  = CNT_W'(T_ALL_RED - 1);
  localparam logic [CNT_W-1:0] WLK_END = CNT_W'(T_WALK - 1);
  state_e           state_q, state_d;
  logic [2:0]       pend_q, pend_d, req, pend_any, in_svc, enter;
  logic [CNT_W-1:0] timer;
  assign req      = {ped_req_i, car_ew_i, car_ns_i};
  assign pend_any = pend_q | req;
  phase_timer #(.CNT_W(CNT_W)) u_timer (
    .clk   (clk),
    .rst_n (rst_n),
    .clr_i (state_d != state_q),
    .cnt_o (timer)
  );
  // next phase: green yields on competing demand within min/max bounds, reds pick the next requester round-robin
  always_comb begin
    state_d = state_q;
    case (state_q)
      G_NS:   if ((pend_any[EW] | pend_any[PED]) && timer >= MIN_END && (!car_ns_i || timer >= MAX_END)) state_d = Y_NS;
      Y_NS:   if (timer >= YEL_END) state_d = R_NS;
      R_NS:   if (timer >= AR_END) state_d = pend_any[EW] ? G_EW : pend_any[PED] ? WALK : G_NS;
      G_EW:   if ((pend_any[NS] | pend_any[PED]) && timer >= MIN_END && (!car_ew_i || timer >= MAX_END)) state_d = Y_EW;
      Y_EW:   if (timer >= YEL_END) state_d = R_EW;
      R_EW:   if (timer >= AR_END) state_d = pend_any[PED] ? WALK : pend_any[NS] ? G_NS : pend_any[EW] ? G_EW : G_NS;
      WALK:   if (timer >= WLK_END) state_d = R_WALK;
      R_WALK: if (timer >= AR_END) state_d = pend_any[NS] ? G_NS : pend_any[EW] ? G_EW : pend_any[PED] ? WALK : G_NS;
      default: state_d = G_NS;
    endcase
  end
  // requests latch outside their own service phase; entering service clears and beats a same-cycle set
  always_comb begin
    in_svc = {state_q == WALK, state_q == G_EW, state_q == G_NS};
    enter  = {state_d == WALK, state_d == G_EW, state_d == G_NS} & ~in_svc;
    pend_d = (pend_q | (req & ~in_svc)) & ~enter;
  end
  // phase and pending-request registers
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= G_NS;
      pend_q  <= '0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
    end
  // lamp decode straight from the phase register
  always_comb begin
    lights_o = state_q == G_NS ? L_G_NS : state_q == Y_NS ? L_Y_NS : state_q == G_EW ? L_G_EW : state_q == Y_EW ? L_Y_EW : L_ALL_RED;
    walk_o   = state_q == WALK;
    phase_o  = state_q;
  end
endmodule

// File: tb/tb_intersection_scheduler.sv
// tb_intersection_scheduler: vector-table and scoreboard bench for the phase sequencer
module tb_intersection_scheduler;
  localparam logic [2:0] GNS = 3'd0, YNS = 3'd1, RNS = 3'd2, GEW = 3'd3;
  localparam logic [2:0] YEW = 3'd4, REW = 3'd5, WLK = 3'd6, RWK = 3'd7;
  typedef struct packed {
    logic       ns;
    logic       ew;
    logic       ped;
    logic [2:0] ph;
  } vec_t;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       car_ns = 1'b0, car_ew = 1'b0, ped_req = 1'b0;
  logic [5:0] lights;
  logic       walk;
  logic [2:0] phase;
  vec_t       vecs[$];
  vec_t       exp_q[$];
  int         errors = 0;
  int         checks = 0;
  always #5 clk = ~clk;
  intersection_scheduler dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .car_ns_i  (car_ns),
    .car_ew_i  (car_ew),
    .ped_req_i (ped_req),
    .lights_o  (lights),
    .walk_o    (walk),
    .phase_o   (phase)
  );
  function automatic logic [5:0] lamp(input logic [2:0] p);
    case (p)
      3'd0:    return 6'b100_001;
      3'd1:    return 6'b010_001;
      3'd3:    return 6'b001_100;
      3'd4:    return 6'b001_010;
      default: return 6'b001_001;
    endcase
  endfunction
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask
  task automatic add(input logic ns, input logic ew, input logic ped, input logic [2:0] ph, input int n);
    vec_t v;
    v = '{ns: ns, ew: ew, ped: ped, ph: ph};
    repeat (n) vecs.push_back(v);
  endtask
  task automatic run(input string tag);
    vec_t e;
    for (int i = 0; i < vecs.size(); i++) begin
      car_ns  = vecs[i].ns;
      car_ew  = vecs[i].ew;
      ped_req = vecs[i].ped;
      exp_q.push_back(vecs[i]);
      @(posedge clk);
      #1;
      e = exp_q.pop_front();
      check($sformatf("%s[%0d].phase", tag, i), 32'(phase), 32'(e.ph));
      check($sformatf("%s[%0d].lights", tag, i), 32'(lights), 32'(lamp(e.ph)));
      check($sformatf("%s[%0d].walk", tag, i), 32'(walk), 32'(e.ph == WLK));
      @(negedge clk);
    end
    car_ns = 1'b0;
    car_ew = 1'b0;
    ped_req = 1'b0;
    vecs.delete();
  endtask
  task automatic check_reset(input string tag);
    check({tag, ".phase"}, 32'(phase), 32'd0);
    check({tag, ".lights"}, 32'(lights), 32'b100_001);
    check({tag, ".walk"}, 32'(walk), 32'd0);
  endtask
  task automatic do_reset(input string tag);
    @(negedge clk);
    rst_n = 1'b0;
    car_ns = 1'b0;
    car_ew = 1'b0;
    ped_req = 1'b0;
    @(negedge clk);
    check_reset(tag);
    rst_n = 1'b1;
  endtask
  always @(negedge clk)
    if (rst_n) begin
      assert (!((lights[5] | lights[4]) && (lights[2] | lights[1])))
        else $error("both directions non-red: %b", lights);
      assert (!(walk && (lights[5] | lights[4] | lights[2] | lights[1])))
        else $error("walk with green/yellow: %b", lights);
    end
  initial begin
    do_reset("rst0");
    add(0, 1, 0, GNS, 1); add(0, 0, 0, GNS, 2); add(0, 0, 0, YNS, 2);
    add(0, 0, 0, RNS, 1); add(0, 0, 0, GEW, 5);
    run("min_green");
    do_reset("rst1");
    add(1, 1, 0, GNS, 9); add(1, 1, 0, YNS, 2); add(1, 1, 0, RNS, 1);
    add(1, 1, 0, GEW, 10); add(1, 1, 0, YEW, 2); add(1, 1, 0, REW, 1);
    add(1, 1, 0, GNS, 1);
    run("max_green");
    do_reset("rst2");
    add(1, 0, 0, GNS, 20); add(1, 1, 0, YNS, 1); add(1, 0, 0, YNS, 1);
    add(1, 0, 0, RNS, 1); add(1, 0, 0, GEW, 4); add(1, 0, 0, YEW, 2);
    add(1, 0, 0, REW, 1); add(1, 0, 0, GNS, 4);
    run("alternate");
    do_reset("rst3");
    add(0, 1, 1, GNS, 1); add(0, 0, 0, GNS, 2); add(0, 0, 0, YNS, 2);
    add(0, 0, 0, RNS, 1); add(0, 0, 0, GEW, 4); add(0, 0, 0, YEW, 2);
    add(0, 0, 0, REW, 1); add(0, 0, 0, WLK, 1); add(0, 0, 1, WLK, 1);
    add(0, 0, 0, WLK, 4); add(0, 0, 0, RWK, 1); add(0, 0, 0, GNS, 8);
    run("ped_cycle");
    do_reset("rst4");
    add(0, 1, 0, GNS, 1); add(0, 0, 0, GNS, 2); add(0, 0, 0, YNS, 2);
    add(0, 0, 0, RNS, 1); add(0, 0, 0, GEW, 1); add(1, 0, 1, GEW, 1);
    add(0, 0, 0, GEW, 2); add(0, 0, 0, YEW, 1);
    run("to_yew");
    #2 rst_n = 1'b0;
    #1 check_reset("async_rst");
    @(negedge clk);
    rst_n = 1'b1;
    add(0, 0, 0, GNS, 8);
    run("after_rst");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
